// File: rtl/icb_rd_pkg.sv
// Shared types and constants for the ICB read master and its response FIFO.
package icb_rd_pkg;

    localparam int unsigned ICB_AW    = 32;
    localparam int unsigned ICB_DW    = 32;
    localparam int unsigned ADDR_STEP = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rd_state_e;

endpackage

// File: rtl/icb_sync_fifo.sv
// Single-clock FIFO with a combinational read port; the head word is visible right after the
// edge that writes it.
module icb_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage is cleared on reset so the read port shows zero while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/icb_rd_master.sv
// ICB read initiator: issues in-order word reads from a latched base address and streams the
// responses to a valid/ready consumer through a credit-protected FIFO.
module icb_rd_master
    import icb_rd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ICB_AW-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              icb_cmd_valid,
    input  logic              icb_cmd_ready,
    output logic              icb_cmd_read,
    output logic [ICB_AW-1:0] icb_cmd_addr,
    output logic [ICB_DW-1:0] icb_cmd_wdata,
    output logic [3:0]        icb_cmd_wmask,
    input  logic              icb_rsp_valid,
    output logic              icb_rsp_ready,
    input  logic [ICB_DW-1:0] icb_rsp_rdata,
    input  logic              icb_rsp_err,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [ICB_DW-1:0] dout_data
);

    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned SUM_W = LEN_W + 2;
    localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ICB_AW-1:0] ALIGN_MASK = ~ICB_AW'(3);

    rd_state_e         state_q;
    logic              busy_q, done_q, err_q, cmd_valid_q, rsp_ready_q;
    logic [ICB_AW-1:0] cmd_addr_q, nxt_addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  cmd_cnt_q, rsp_cnt_q, len_x;
    logic [SUM_W-1:0]  credit_used;
    logic              cmd_fire, rsp_fire, can_issue;
    logic              fifo_pop, fifo_full, fifo_empty;
    logic [FCW-1:0]    fifo_count;

    assign len_x    = {1'b0, len_q};
    assign cmd_fire = cmd_valid_q & icb_cmd_ready;
    assign rsp_fire = icb_rsp_valid & rsp_ready_q & (state_q != IDLE);
    assign fifo_pop = dout_ready & ~fifo_empty;

    // cmd_cnt_q counts commands already presented, so the pending one holds a credit too.
    assign credit_used = SUM_W'(cmd_cnt_q - rsp_cnt_q) + SUM_W'(fifo_count);
    assign can_issue   = (cmd_cnt_q < len_x) && (credit_used < SUM_W'(FIFO_DEPTH)) && !fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            cmd_addr_q  <= '0;
            nxt_addr_q  <= '0;
            len_q       <= '0;
            cmd_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
        end else begin
            done_q      <= 1'b0;
            rsp_ready_q <= 1'b1;
            if (rsp_fire) begin
                rsp_cnt_q <= rsp_cnt_q + CNT_W'(1);
                if (icb_rsp_err) begin
                    err_q <= 1'b1;
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        if (len != '0) begin
                            // First command goes out on the edge that accepts start.
                            state_q     <= RUN;
                            busy_q      <= 1'b1;
                            len_q       <= len;
                            cmd_cnt_q   <= CNT_W'(1);
                            rsp_cnt_q   <= '0;
                            cmd_valid_q <= 1'b1;
                            cmd_addr_q  <= base_addr & ALIGN_MASK;
                            nxt_addr_q  <= (base_addr & ALIGN_MASK) + ICB_AW'(ADDR_STEP);
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!cmd_valid_q || cmd_fire) begin
                        if (can_issue) begin
                            cmd_valid_q <= 1'b1;
                            cmd_addr_q  <= nxt_addr_q;
                            nxt_addr_q  <= nxt_addr_q + ICB_AW'(ADDR_STEP);
                            cmd_cnt_q   <= cmd_cnt_q + CNT_W'(1);
                        end else begin
                            cmd_valid_q <= 1'b0;
                        end
                    end
                    if (cmd_fire && (cmd_cnt_q == len_x)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((rsp_cnt_q == len_x) && fifo_empty) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    icb_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ICB_DW)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_fire),
        .wdata (icb_rsp_rdata),
        .pop   (fifo_pop),
        .rdata (dout_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign icb_cmd_valid = cmd_valid_q;
    assign icb_cmd_addr  = cmd_addr_q;
    assign icb_cmd_read  = 1'b1;
    assign icb_cmd_wdata = '0;
    assign icb_cmd_wmask = '0;
    assign icb_rsp_ready = rsp_ready_q;
    assign dout_valid    = ~fifo_empty;

endmodule

// File: tb/tb_icb_rd_master.sv
// Bench for icb_rd_master: table of transfers against an in-order ICB memory model, plus
// hand-written backpressure, corner-start and reset sequences.
module tb_icb_rd_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, err;
    logic        icb_cmd_valid, icb_cmd_read;
    logic        icb_cmd_ready = 1'b1;
    logic [31:0] icb_cmd_addr, icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid = 1'b0;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata = '0;
    logic        icb_rsp_err = 1'b0;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [31:0] dout_data;

    always #5 clk = ~clk;

    icb_rd_master #(
        .FIFO_DEPTH (4),
        .LEN_W      (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .dout_data     (dout_data)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] addr_log[$];
    logic [31:0] word_log[$];
    logic [31:0] stall_log[$];
    logic [31:0] rsp_q[$];
    int rsp_n      = 0;
    int err_idx    = -1;
    int stall_left = 0;
    int done_cnt   = 0;
    bit dout_en    = 1'b1;
    bit stray_req  = 1'b0;

    // Memory model: data = address, one response per cycle, earliest the cycle after handshake.
    always @(negedge clk) begin
        dout_ready = dout_en;
        if (!rst_n) begin
            rsp_q.delete();
            icb_rsp_valid = 1'b0;
            icb_rsp_err   = 1'b0;
            icb_cmd_ready = 1'b1;
        end else begin
            if (done) done_cnt++;
            if (dout_valid && dout_ready) word_log.push_back(dout_data);
            if (stray_req) begin
                icb_rsp_valid = 1'b1;
                icb_rsp_rdata = 32'hDEAD_BEEF;
                icb_rsp_err   = 1'b0;
                stray_req     = 1'b0;
            end else if (rsp_q.size() > 0) begin
                icb_rsp_valid = 1'b1;
                icb_rsp_rdata = rsp_q.pop_front();
                icb_rsp_err   = (rsp_n == err_idx);
                rsp_n++;
            end else begin
                icb_rsp_valid = 1'b0;
                icb_rsp_err   = 1'b0;
            end
            icb_cmd_ready = 1'b1;
            if (icb_cmd_valid && addr_log.size() == 1 && stall_left > 0) begin
                icb_cmd_ready = 1'b0;
                stall_left--;
                stall_log.push_back(icb_cmd_addr);
            end
            if (icb_cmd_valid && icb_cmd_ready) begin
                addr_log.push_back(icb_cmd_addr);
                rsp_q.push_back(icb_cmd_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_valid"}, 32'(icb_cmd_valid), 32'd0);
        chk({tag, "_cmd_addr"}, icb_cmd_addr, 32'd0);
        chk({tag, "_cmd_read"}, 32'(icb_cmd_read), 32'd1);
        chk({tag, "_cmd_wdata"}, icb_cmd_wdata, 32'd0);
        chk({tag, "_cmd_wmask"}, 32'(icb_cmd_wmask), 32'd0);
        chk({tag, "_rsp_ready"}, 32'(icb_rsp_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_dout_data"}, dout_data, 32'd0);
    endtask

    task automatic start_xfer(input logic [31:0] b, input logic [15:0] l, input int eidx,
                              input int stall);
        addr_log.delete();
        word_log.delete();
        stall_log.delete();
        rsp_n      = 0;
        err_idx    = eidx;
        stall_left = stall;
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, 32'(done_cnt > d0), 32'd1);
        repeat (3) @(negedge clk);
        chk({name, "_one_done"}, 32'(done_cnt), 32'(d0 + 1));
    endtask

    // Address log and output words must both be base+4k for k = 0..n-1.
    task automatic chk_stream(input string name, input logic [31:0] b, input int n);
        logic [31:0] exp;
        chk({name, "_n_cmds"}, 32'(addr_log.size()), 32'(n));
        chk({name, "_n_words"}, 32'(word_log.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            exp = (b & ~32'h3) + 32'(4 * k);
            if (k < addr_log.size()) chk($sformatf("%s_addr%0d", name, k), addr_log[k], exp);
            if (k < word_log.size()) chk($sformatf("%s_word%0d", name, k), word_log[k], exp);
        end
    endtask

    typedef struct {
        logic [31:0] base;
        logic [15:0] len;
        int          eidx;
        int          stall;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin : main
        int d0;
        int n;
        vecs[0] = '{32'h0000_1000, 16'd4, -1, 0, 32'h0000_1000, 32'h0000_100C, 1'b0};
        vecs[1] = '{32'h0000_2003, 16'd5, -1, 0, 32'h0000_2000, 32'h0000_2010, 1'b0};
        vecs[2] = '{32'h0000_5000, 16'd4, -1, 3, 32'h0000_5000, 32'h0000_500C, 1'b0};
        vecs[3] = '{32'h0000_0040, 16'd1, -1, 0, 32'h0000_0040, 32'h0000_0040, 1'b0};
        vecs[4] = '{32'hFFFF_FFF8, 16'd3, 1, 0, 32'hFFFF_FFF8, 32'h0000_0000, 1'b1};

        #12;
        chk_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rsp_ready_after_reset", 32'(icb_rsp_ready), 32'd1);

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            d0 = done_cnt;
            start_xfer(vecs[i].base, vecs[i].len, vecs[i].eidx, vecs[i].stall);
            chk({nm, "_cmd_valid_rise"}, 32'(icb_cmd_valid), 32'd1);
            chk({nm, "_busy"}, 32'(busy), 32'd1);
            chk({nm, "_err_cleared"}, 32'(err), 32'd0);
            wait_done(nm, d0, 200);
            chk_stream(nm, vecs[i].base, int'(vecs[i].len));
            if (addr_log.size() > 0) begin
                chk({nm, "_first"}, addr_log[0], vecs[i].exp_first);
                chk({nm, "_last"}, addr_log[addr_log.size() - 1], vecs[i].exp_last);
            end
            chk({nm, "_err"}, 32'(err), 32'(vecs[i].exp_err));
            chk({nm, "_busy_end"}, 32'(busy), 32'd0);
            chk({nm, "_n_stall"}, 32'(stall_log.size()), 32'(vecs[i].stall));
            foreach (stall_log[k]) begin
                chk($sformatf("%s_stall_addr%0d", nm, k), stall_log[k], vecs[i].exp_first + 32'd4);
            end
        end

        // len=0 after the error transfer: immediate done, err cleared, no command.
        d0 = done_cnt;
        start_xfer(32'h0000_A000, 16'd0, -1, 0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_err_cleared", 32'(err), 32'd0);
        repeat (5) @(negedge clk);
        chk("len0_no_cmd", 32'(addr_log.size()), 32'd0);
        chk("len0_one_done", 32'(done_cnt), 32'(d0 + 1));

        // Backpressure: only FIFO_DEPTH reads may be in flight or buffered.
        dout_en = 1'b0;
        d0 = done_cnt;
        start_xfer(32'h0000_3000, 16'd10, -1, 0);
        repeat (30) @(negedge clk);
        chk("bp_cmds_capped", 32'(addr_log.size()), 32'd4);
        chk("bp_cmd_valid_low", 32'(icb_cmd_valid), 32'd0);
        chk("bp_dout_valid", 32'(dout_valid), 32'd1);
        chk("bp_dout_head", dout_data, 32'h0000_3000);
        dout_en = 1'b1;
        wait_done("bp", d0, 300);
        chk_stream("bp", 32'h0000_3000, 10);

        // start while busy is ignored.
        d0 = done_cnt;
        start_xfer(32'h0000_6000, 16'd6, -1, 0);
        @(negedge clk);
        start     = 1'b1;
        base_addr = 32'h0000_9000;
        len       = 16'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", d0, 200);
        chk_stream("busy_start", 32'h0000_6000, 6);

        // Reset after two of eight responses.
        start_xfer(32'h0000_7000, 16'd8, -1, 0);
        n = 0;
        while (rsp_n < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_two_rsps", 32'(rsp_n >= 2), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        word_log.delete();
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("stray_dropped_valid", 32'(dout_valid), 32'd0);
        chk("stray_no_word", 32'(word_log.size()), 32'd0);
        chk("rst_no_done", 32'(done_cnt), 32'(d0));
        chk("rst_busy", 32'(busy), 32'd0);
        start_xfer(32'h0000_8000, 16'd2, -1, 0);
        wait_done("post_rst", d0, 200);
        chk_stream("post_rst", 32'h0000_8000, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/icb_rd_master.md
# icb_rd_master

ICB initiator that fetches a block of 32-bit words from system memory and streams them to a downstream consumer. It is the bus-master counterpart of the accelerator's ICB register slave. Firmware programs the base read address and length through the slave, then pulses start. This block issues in-order ICB read commands, buffers responses in a small FIFO, and reports completion.

## Interface
- `FIFO_DEPTH`, 4: response buffer depth in words; also the maximum number of outstanding reads (power of two, 2..16).
- `LEN_W`, 16: width of the transfer length in words.
- `clk`  in  1  system clock; the block has one clock, all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle pulse; starts a transfer. Ignored while `busy`=1.
- `base_addr`  in  32  byte address of the first word; sampled on accepted `start`. Bits [1:0] are ignored (treated as 0).
- `len`  in  LEN_W  number of words; sampled on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky; set by any `icb_rsp_err`; cleared by the next accepted start.
- `icb_cmd_valid`  out  1  command request.
- `icb_cmd_ready`  in  1  command accept.
- `icb_cmd_read`  out  1  constant 1.
- `icb_cmd_addr`  out  32  word address.
- `icb_cmd_wdata`  out  32  constant 0.
- `icb_cmd_wmask`  out  4  constant 0.
- `icb_rsp_valid`  in  1  response valid.
- `icb_rsp_ready`  out  1  response accept.
- `icb_rsp_rdata`  in  32  read data.
- `icb_rsp_err`  in  1  response error.
- `dout_valid`, `dout_ready`, `dout_data`[31:0]  out/in/out  downstream valid/ready stream.

## Operation
- FSM states are `IDLE`, `RUN` and `DRAIN`.
- `IDLE` → `RUN`: on `start` with `len`≠0. The block latches `base_addr` and `len`, clears `cmd_cnt`, `rsp_cnt` and `err`.
- `IDLE` with `start` and `len`=0: `done` pulses the next cycle, `busy` stays 0, and `err` is cleared.
- `RUN` issues commands:
  - The address of command `i` is `base + 4*i`, modulo 2^32; wrap-around is silent.
  - A command is issued only if `cmd_cnt < len` and `(cmd_cnt - rsp_cnt) + fifo_count < FIFO_DEPTH`. This credit rule guarantees FIFO space for every response.
- `RUN` → `DRAIN`: when `cmd_cnt == len` and the last command handshake completes.
- `DRAIN` → `IDLE`: when `rsp_cnt == len` and the FIFO is empty, i.e. the last word has been consumed by the downstream. `done` pulses on this transition.
- Responses:
  - `icb_rsp_ready` is held at 1 whenever out of reset.
  - In `RUN`/`DRAIN`, each response pushes `icb_rsp_rdata` into the FIFO and increments `rsp_cnt`.
  - Responses are in order, as required by ICB.
  - A response with `icb_rsp_err`=1 sets `err`; its data is still pushed and the transfer continues.
  - A response arriving in `IDLE` (stray, e.g. after a reset) is dropped.
- Arithmetic: `cmd_cnt` and `rsp_cnt` are LEN_W+1 bits wide, so `len`=2^LEN_W−1 does not overflow. The outstanding count is `cmd_cnt - rsp_cnt`.

## Timing
- Reset values:
  - `icb_cmd_valid`=0, `icb_cmd_addr`=0, `icb_cmd_read`=1, `icb_cmd_wdata`=0, `icb_cmd_wmask`=0.
  - `icb_rsp_ready`=0.
  - `busy`=0, `done`=0, `err`=0, `dout_valid`=0, `dout_data`=0.
  - FSM in `IDLE`, FIFO empty.
- All ICB command outputs are registered. `icb_cmd_valid` first rises 1 cycle after `start`.
- While `icb_cmd_valid`=1 and `icb_cmd_ready`=0, `icb_cmd_addr` is held stable.
- After a command handshake, the next command may be presented the following cycle, i.e. back-to-back at one per cycle when credits allow.
- A response may arrive no earlier than the cycle after its command handshake.
- A response push and a downstream pop may occur in the same cycle. `fifo_count` is unchanged in that case, and the credit check uses the registered count.
- FIFO latency: a word pushed at edge N is visible on `dout_valid`/`dout_data` after edge N.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously), the FIFO is flushed, no `done` pulse is generated, and late responses are dropped.

## Structure
- Package `icb_rd_pkg` holds:
  - the state enum `rd_state_e` {`IDLE`, `RUN`, `DRAIN`};
  - `localparam ADDR_STEP = 4`;
  - the ICB width constants (`ICB_AW` = 32, `ICB_DW` = 32).
- One sub-module, `icb_sync_fifo`:
  - parameterised depth and width;
  - ports push, pop, full, empty, count;
  - asynchronous active-low reset.

## Test plan
- **Basic read:** base=0x1000, len=4, slave with ready=1 and response latency 1; data = the address → addresses 0x1000/4/8/C in order, `dout` gives 0x1000..0x100C, one `done`, `err`=0.
- **Backpressure:** `dout_ready`=0, len=10 → at most 4 commands issued, then `icb_cmd_valid`=0 until pops. Releasing `dout_ready` completes all 10 words in order.
- **Command stall:** `icb_cmd_ready` low for 3 cycles on the 2nd command → `icb_cmd_addr` stays at base+4 throughout, with no duplicate or skipped address.
- **Error and wrap:** base=0xFFFF_FFF8, len=3, `icb_rsp_err` on the 2nd response → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. `err`=1 after completion, 3 words output, then the next start clears `err`.
- **Corner starts:** len=0 → `done` the next cycle, no ICB command. `start` while busy → ignored, transfer unchanged.
- **Reset mid-transfer:** `rst_n` low after 2 of 8 responses → all outputs at reset values in the same cycle, no `done`. A stray response after reset is dropped, and a subsequent len=2 transfer outputs exactly 2 words.
